flag_branch_unit: RTL and testbench

- Sits downstream of the ALU in the 16-bit RISC datapath.
- Holds the architectural zero/carry flag register, updated from the ALU result stream.
- Resolves conditional branches from decode against those flags, forwarding a same-cycle ALU result when needed.
- Drives a held PC-redirect handshake to fetch.

---
 rtl/flag_branch_unit.sv | 192 +++++++++++++++++++
 tb/tb_flag_branch_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/flag_branch_unit.sv
// flag_branch_unit: zero/carry flag register plus conditional branch resolver.
// Sits after the ALU, resolves decode branches against the flags (forwarding a
// same-cycle ALU result) and drives a held PC-redirect handshake to fetch.
// Optional macro BRANCH_STATS_EN adds saturating taken / not-taken counters.
module flag_branch_unit #(
    parameter int unsigned PC_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            res_valid_i,
    input  logic            res_upd_i,
    input  logic            res_zero_i,
    input  logic            res_carry_i,
    input  logic            br_valid_i,
    output logic            br_ready_o,
    input  logic [1:0]      br_cond_i,
    input  logic            br_dep_i,
    input  logic [PC_W-1:0] br_target_i,
    output logic            br_done_o,
    output logic            br_taken_o,
    output logic            redirect_valid_o,
    input  logic            redirect_ready_i,
    output logic [PC_W-1:0] redirect_pc_o,
`ifdef BRANCH_STATS_EN
    output logic [15:0]     stat_taken_o,
    output logic [15:0]     stat_not_taken_o,
`endif
    output logic [1:0]      flags_o
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StWait  = 2'd1;
    localparam logic [1:0] StRedir = 2'd2;

    localparam logic [1:0] CondZ    = 2'b00;
    localparam logic [1:0] CondNz   = 2'b01;
    localparam logic [1:0] CondC    = 2'b10;
    localparam logic [1:0] CondAlways = 2'b11;

    logic [1:0]      state_q, state_d;
    logic [1:0]      flags_q, flags_d;
    logic [1:0]      cond_q, cond_d;
    logic [PC_W-1:0] target_q, target_d;
    logic            done_q, done_d;
    logic            taken_q, taken_d;
    logic            rv_q, rv_d;
    logic [PC_W-1:0] rpc_q, rpc_d;

    logic            upd;
    logic [1:0]      eff_flags;
    logic            eval;
    logic [1:0]      eval_cond;
    logic [PC_W-1:0] eval_target;
    logic            eval_res;

    // flags are {carry, zero}
    function automatic logic cond_met(input logic [1:0] cond, input logic [1:0] fl);
        logic r;
        r = 1'b0;
        unique case (cond)
            CondZ:      r = fl[0];
            CondNz:     r = ~fl[0];
            CondC:      r = fl[1];
            CondAlways: r = 1'b1;
            default:    r = 1'b0;
        endcase
        return r;
    endfunction

    assign upd       = res_valid_i & res_upd_i;
    assign eff_flags = upd ? {res_carry_i, res_zero_i} : flags_q;
    assign flags_d   = eff_flags;

    // Next-state: accept, wait for a flag-writing result, evaluate, redirect.
    always_comb begin
        state_d     = state_q;
        cond_d      = cond_q;
        target_d    = target_q;
        done_d      = 1'b0;
        taken_d     = taken_q;
        rv_d        = rv_q;
        rpc_d       = rpc_q;
        eval        = 1'b0;
        eval_cond   = cond_q;
        eval_target = target_q;

        unique case (state_q)
            StIdle: begin
                if (br_valid_i) begin
                    cond_d      = br_cond_i;
                    target_d    = br_target_i;
                    eval_cond   = br_cond_i;
                    eval_target = br_target_i;
                    // Unconditional branches never depend on flags, so never wait.
                    if (br_dep_i && !upd && br_cond_i != CondAlways) begin
                        state_d = StWait;
                    end else begin
                        eval = 1'b1;
                    end
                end
            end
            StWait: begin
                if (upd) begin
                    eval = 1'b1;
                end
            end
            StRedir: begin
                if (redirect_ready_i) begin
                    state_d = StIdle;
                    rv_d    = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        eval_res = cond_met(eval_cond, eff_flags);
        if (eval) begin
            done_d  = 1'b1;
            taken_d = eval_res;
            if (eval_res) begin
                state_d = StRedir;
                rv_d    = 1'b1;
                rpc_d   = eval_target;
            end else begin
                state_d = StIdle;
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            flags_q  <= 2'b00;
            cond_q   <= 2'b00;
            target_q <= '0;
            done_q   <= 1'b0;
            taken_q  <= 1'b0;
            rv_q     <= 1'b0;
            rpc_q    <= '0;
        end else begin
            state_q  <= state_d;
            flags_q  <= flags_d;
            cond_q   <= cond_d;
            target_q <= target_d;
            done_q   <= done_d;
            taken_q  <= taken_d;
            rv_q     <= rv_d;
            rpc_q    <= rpc_d;
        end
    end

`ifdef BRANCH_STATS_EN
    logic [15:0] stat_t_q, stat_t_d;
    logic [15:0] stat_nt_q, stat_nt_d;

    // Saturating counters step in the same edge that raises br_done.
    always_comb begin
        stat_t_d  = stat_t_q;
        stat_nt_d = stat_nt_q;
        if (done_d) begin
            if (taken_d) begin
                if (stat_t_q != 16'hFFFF) stat_t_d = stat_t_q + 16'd1;
            end else begin
                if (stat_nt_q != 16'hFFFF) stat_nt_d = stat_nt_q + 16'd1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_t_q  <= 16'd0;
            stat_nt_q <= 16'd0;
        end else begin
            stat_t_q  <= stat_t_d;
            stat_nt_q <= stat_nt_d;
        end
    end

    assign stat_taken_o     = stat_t_q;
    assign stat_not_taken_o = stat_nt_q;
`endif

    assign br_ready_o       = (state_q == StIdle);
    assign br_done_o        = done_q;
    assign br_taken_o       = taken_q;
    assign redirect_valid_o = rv_q;
    assign redirect_pc_o    = rpc_q;
    assign flags_o          = flags_q;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed-vector bench for flag_branch_unit.
module tb_flag_branch_unit;

    localparam int unsigned PC_W = 16;

    logic            clk;
    logic            rst_n;
    logic            res_valid, res_upd, res_zero, res_carry;
    logic            br_valid, br_ready, br_dep;
    logic [1:0]      br_cond;
    logic [PC_W-1:0] br_target;
    logic            br_done, br_taken;
    logic            redirect_valid, redirect_ready;
    logic [PC_W-1:0] redirect_pc;
    logic [1:0]      flags;
`ifdef BRANCH_STATS_EN
    logic [15:0]     stat_taken, stat_not_taken;
`endif

    int n_cmp;
    int n_err;

    flag_branch_unit #(.PC_W(PC_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .res_valid_i      (res_valid),
        .res_upd_i        (res_upd),
        .res_zero_i       (res_zero),
        .res_carry_i      (res_carry),
        .br_valid_i       (br_valid),
        .br_ready_o       (br_ready),
        .br_cond_i        (br_cond),
        .br_dep_i         (br_dep),
        .br_target_i      (br_target),
        .br_done_o        (br_done),
        .br_taken_o       (br_taken),
        .redirect_valid_o (redirect_valid),
        .redirect_ready_i (redirect_ready),
        .redirect_pc_o    (redirect_pc),
`ifdef BRANCH_STATS_EN
        .stat_taken_o     (stat_taken),
        .stat_not_taken_o (stat_not_taken),
`endif
        .flags_o          (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_res(input logic v, input logic u, input logic z, input logic c);
        res_valid = v;
        res_upd   = u;
        res_zero  = z;
        res_carry = c;
    endtask

    task automatic set_br(input logic v, input logic [1:0] cond, input logic dep,
                          input logic [PC_W-1:0] tgt);
        br_valid  = v;
        br_cond   = cond;
        br_dep    = dep;
        br_target = tgt;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        redirect_ready = 1'b0;
        set_res(0, 0, 0, 0);
        set_br(0, 2'b00, 0, 16'h0000);

        // Reset values
        #12;
        check_eq("rst_flags", {30'd0, flags}, 32'h0);
        check_eq("rst_ready", {31'd0, br_ready}, 32'h1);
        check_eq("rst_done", {31'd0, br_done}, 32'h0);
        check_eq("rst_taken", {31'd0, br_taken}, 32'h0);
        check_eq("rst_rv", {31'd0, redirect_valid}, 32'h0);
        check_eq("rst_pc", {16'd0, redirect_pc}, 32'h0);
        rst_n = 1'b1;
        tick();
        tick();
        check_eq("idle_done", {31'd0, br_done}, 32'h0);
        check_eq("idle_ready", {31'd0, br_ready}, 32'h1);

        // Forwarding: BEQ sees zero=1 from same-cycle result
        set_res(1, 1, 1, 0);
        set_br(1, 2'b00, 0, 16'h0040);
        tick();
        set_res(0, 0, 0, 0);
        set_br(0, 2'b00, 0, 16'h0000);
        check_eq("fwd_done", {31'd0, br_done}, 32'h1);
        check_eq("fwd_taken", {31'd0, br_taken}, 32'h1);
        check_eq("fwd_rv", {31'd0, redirect_valid}, 32'h1);
        check_eq("fwd_pc", {16'd0, redirect_pc}, 32'h0040);
        check_eq("fwd_flags", {30'd0, flags}, 32'h1);
        check_eq("fwd_ready", {31'd0, br_ready}, 32'h0);
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        check_eq("fwd_rv_drop", {31'd0, redirect_valid}, 32'h0);
        check_eq("fwd_done_pulse", {31'd0, br_done}, 32'h0);
        check_eq("fwd_ready_back", {31'd0, br_ready}, 32'h1);

        // Dependent wait: BNE, flags Z=1 currently
        set_br(1, 2'b01, 1, 16'h0100);
        tick();
        set_br(0, 2'b00, 0, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            check_eq("wait_ready", {31'd0, br_ready}, 32'h0);
            check_eq("wait_done", {31'd0, br_done}, 32'h0);
            tick();
        end
        set_res(1, 0, 0, 0);
        tick();
        check_eq("wait_noupd_done", {31'd0, br_done}, 32'h0);
        check_eq("wait_noupd_ready", {31'd0, br_ready}, 32'h0);
        check_eq("wait_noupd_flags", {30'd0, flags}, 32'h1);
        set_res(1, 1, 1, 1);
        tick();
        set_res(0, 0, 0, 0);
        check_eq("wait_done", {31'd0, br_done}, 32'h1);
        check_eq("wait_taken", {31'd0, br_taken}, 32'h0);
        check_eq("wait_rv", {31'd0, redirect_valid}, 32'h0);
        check_eq("wait_ready_back", {31'd0, br_ready}, 32'h1);
        check_eq("wait_flags", {30'd0, flags}, 32'h3);

        // Redirect backpressure: BC with carry=1
        set_br(1, 2'b10, 0, 16'h1234);
        tick();
        set_br(0, 2'b00, 0, 16'h0000);
        check_eq("bp_done", {31'd0, br_done}, 32'h1);
        check_eq("bp_taken", {31'd0, br_taken}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            check_eq("bp_rv", {31'd0, redirect_valid}, 32'h1);
            check_eq("bp_pc", {16'd0, redirect_pc}, 32'h1234);
            check_eq("bp_ready", {31'd0, br_ready}, 32'h0);
            tick();
        end
        check_eq("bp_done_once", {31'd0, br_done}, 32'h0);
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        check_eq("bp_rv_drop", {31'd0, redirect_valid}, 32'h0);
        check_eq("bp_ready_back", {31'd0, br_ready}, 32'h1);

        // Back-to-back not-taken BEQ (clear flags first)
        set_res(1, 1, 0, 0);
        tick();
        set_res(0, 0, 0, 0);
        check_eq("clr_flags", {30'd0, flags}, 32'h0);
        set_br(1, 2'b00, 0, 16'h0200);
        tick();
        check_eq("nt1_done", {31'd0, br_done}, 32'h1);
        check_eq("nt1_taken", {31'd0, br_taken}, 32'h0);
        check_eq("nt1_ready", {31'd0, br_ready}, 32'h1);
        tick();
        set_br(0, 2'b00, 0, 16'h0000);
        check_eq("nt2_done", {31'd0, br_done}, 32'h1);
        check_eq("nt2_rv", {31'd0, redirect_valid}, 32'h0);
        tick();
        check_eq("nt_quiet", {31'd0, br_done}, 32'h0);

        // Always-taken ignores br_dep; then reset mid-redirect
        set_res(1, 1, 1, 1);
        set_br(1, 2'b11, 1, 16'hBEEF);
        tick();
        set_res(0, 0, 0, 0);
        set_br(0, 2'b00, 0, 16'h0000);
        check_eq("al_done", {31'd0, br_done}, 32'h1);
        check_eq("al_taken", {31'd0, br_taken}, 32'h1);
        check_eq("al_pc", {16'd0, redirect_pc}, 32'hBEEF);
        check_eq("al_flags", {30'd0, flags}, 32'h3);
        tick();
        check_eq("al_rv_hold", {31'd0, redirect_valid}, 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("arst_rv", {31'd0, redirect_valid}, 32'h0);
        check_eq("arst_flags", {30'd0, flags}, 32'h0);
        check_eq("arst_pc", {16'd0, redirect_pc}, 32'h0);
        check_eq("arst_ready", {31'd0, br_ready}, 32'h1);
        #3;
        rst_n = 1'b1;
        tick();
        check_eq("post_rst_done", {31'd0, br_done}, 32'h0);
        check_eq("post_rst_rv", {31'd0, redirect_valid}, 32'h0);

`ifdef BRANCH_STATS_EN
        // 3 taken (always) and 2 not-taken (BC with carry=0)
        redirect_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_br(1, 2'b11, 0, 16'h0010);
            tick();
            set_br(0, 2'b00, 0, 16'h0000);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            set_br(1, 2'b10, 0, 16'h0020);
            tick();
            set_br(0, 2'b00, 0, 16'h0000);
            tick();
        end
        redirect_ready = 1'b0;
        check_eq("stat_taken", {16'd0, stat_taken}, 32'd3);
        check_eq("stat_not_taken", {16'd0, stat_not_taken}, 32'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
